// File: rtl/ga_pkg.sv
// Shared GA parameters and selector FSM encoding, common to selection, mutation and iteration.
// Latency: n/a. Backpressure: n/a.
package ga_pkg;

  localparam int PATH_W = 75;
  localparam int POP_N  = 25;
  localparam int SEL_N  = 5;
  localparam int FIT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/topk_insert.sv
// Combinational insert of one (fitness, index) candidate into a sorted top-N list.
// Latency: 0 cycles. Backpressure: none.
module topk_insert #(
  parameter int SEL_N = 5,
  parameter int FIT_W = 16,
  parameter int IDX_W = 5
) (
  input  logic [SEL_N-1:0]            cur_vld,
  input  logic [SEL_N-1:0][FIT_W-1:0] cur_fit,
  input  logic [SEL_N-1:0][IDX_W-1:0] cur_idx,
  input  logic [FIT_W-1:0]            cand_fit,
  input  logic [IDX_W-1:0]            cand_idx,
  output logic [SEL_N-1:0]            nxt_vld,
  output logic [SEL_N-1:0][FIT_W-1:0] nxt_fit,
  output logic [SEL_N-1:0][IDX_W-1:0] nxt_idx
);

  logic [SEL_N-1:0] beats;

  // Strict compare keeps earlier (lower index) entries ahead on ties. Because the
  // list is sorted with invalid entries trailing, beats is monotone in k.
  always_comb begin
    beats = '0;
    for (int k = 0; k < SEL_N; k++) begin
      beats[k] = !cur_vld[k] || (cur_fit[k] > cand_fit);
    end
  end

  always_comb begin
    nxt_vld = cur_vld;
    nxt_fit = cur_fit;
    nxt_idx = cur_idx;
    if (beats[0]) begin
      nxt_vld[0] = 1'b1;
      nxt_fit[0] = cand_fit;
      nxt_idx[0] = cand_idx;
    end
    for (int k = 1; k < SEL_N; k++) begin
      if (beats[k-1]) begin
        nxt_vld[k] = cur_vld[k-1];
        nxt_fit[k] = cur_fit[k-1];
        nxt_idx[k] = cur_idx[k-1];
      end else if (beats[k]) begin
        nxt_vld[k] = 1'b1;
        nxt_fit[k] = cand_fit;
        nxt_idx[k] = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fitness_selector.sv
// Keeps the SEL_N lowest-fitness paths of a captured population, one candidate per cycle.
// Latency: POP_N+1 clocks start-to-done. Backpressure: none; start is ignored while busy.
module fitness_selector #(
  parameter int PATH_W = ga_pkg::PATH_W,
  parameter int POP_N  = ga_pkg::POP_N,
  parameter int SEL_N  = ga_pkg::SEL_N,
  parameter int FIT_W  = ga_pkg::FIT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [POP_N*PATH_W-1:0] population,
  input  logic [POP_N*FIT_W-1:0]  fitness,
  output logic [SEL_N*PATH_W-1:0] sel_population,
  output logic                    done
);
  import ga_pkg::*;

  localparam int IDX_W = $clog2(POP_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_N - 1);

  state_t                      state;
  logic [IDX_W-1:0]            cnt;
  logic [POP_N*PATH_W-1:0]     pop_q;
  logic [POP_N*FIT_W-1:0]      fit_q;
  logic [SEL_N-1:0]            lst_vld, nxt_vld;
  logic [SEL_N-1:0][FIT_W-1:0] lst_fit, nxt_fit;
  logic [SEL_N-1:0][IDX_W-1:0] lst_idx, nxt_idx;
  logic [FIT_W-1:0]            cand_fit;
  logic [SEL_N*PATH_W-1:0]     sel_nxt;

  assign cand_fit = fit_q[int'(cnt)*FIT_W +: FIT_W];

  topk_insert #(
    .SEL_N (SEL_N),
    .FIT_W (FIT_W),
    .IDX_W (IDX_W)
  ) u_topk (
    .cur_vld  (lst_vld),
    .cur_fit  (lst_fit),
    .cur_idx  (lst_idx),
    .cand_fit (cand_fit),
    .cand_idx (cnt),
    .nxt_vld  (nxt_vld),
    .nxt_fit  (nxt_fit),
    .nxt_idx  (nxt_idx)
  );

  // Unfilled slots (only possible if POP_N < SEL_N) come out as zero paths.
  always_comb begin
    sel_nxt = '0;
    for (int k = 0; k < SEL_N; k++) begin
      if (lst_vld[k]) begin
        sel_nxt[k*PATH_W +: PATH_W] = pop_q[int'(lst_idx[k])*PATH_W +: PATH_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pop_q          <= '0;
      fit_q          <= '0;
      lst_vld        <= '0;
      lst_fit        <= '0;
      lst_idx        <= '0;
      sel_population <= '0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pop_q   <= population;
            fit_q   <= fitness;
            lst_vld <= '0;
            cnt     <= '0;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          lst_vld <= nxt_vld;
          lst_fit <= nxt_fit;
          lst_idx <= nxt_idx;
          cnt     <= cnt + IDX_W'(1);
          if (cnt == LAST_IDX) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          sel_population <= sel_nxt;
          done           <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
